// File: rtl/fp_scoreboard_pkg.sv
// Shared FP register-file constants, ID-field bundle and hazard bits.
// Imported by the FP scoreboard and its hazard checker.
package fp_scoreboard_pkg;

  localparam int FP_NUM_REGS  = 32;
  localparam int FP_REG_IDX_W = 5;

  typedef logic [FP_REG_IDX_W-1:0] fp_idx_t;
  typedef logic [FP_NUM_REGS-1:0]  fp_mask_t;

  // Op-class encoding shared with the decoder.
  typedef enum logic [1:0] {
    FP_OPC_NONE = 2'd0,
    FP_OPC_SC   = 2'd1,
    FP_OPC_MC   = 2'd2
  } fp_opc_e;

  typedef struct packed {
    logic    valid;
    fp_idx_t rs1;
    fp_idx_t rs2;
    fp_idx_t rs3;
    logic    use1;
    logic    use2;
    logic    use3;
    fp_idx_t rd;
    logic    rw;
    logic    is_mc;
  } id_fp_t;

  typedef struct packed {
    logic raw;
    logic waw;
    logic str;
  } fp_haz_t;

  function automatic fp_mask_t fp_onehot(input fp_idx_t i);
    return fp_mask_t'(1) << i;
  endfunction

endpackage

// File: rtl/fp_sb_hazard_check.sv
// Combinational RAW / WAW / structural hazard detection for ID.
// In: pending mask, outstanding count, ID fields. Out: hazard bits, stall.
module fp_sb_hazard_check
  import fp_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  fp_mask_t         i_pending,
  input  logic [CNT_W-1:0] i_outstanding,
  input  id_fp_t           i_id,
  output fp_haz_t          o_haz,
  output logic             o_stall
);

  logic w_full;

  assign w_full =
    (i_outstanding == CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    o_haz = '0;
    o_haz.raw = i_id.valid &&
      ((i_id.use1 && i_pending[i_id.rs1]) ||
       (i_id.use2 && i_pending[i_id.rs2]) ||
       (i_id.use3 && i_pending[i_id.rs3]));
    o_haz.waw = i_id.valid && i_id.rw &&
      i_pending[i_id.rd];
    o_haz.str = i_id.valid && i_id.is_mc &&
      w_full;
    o_stall = o_haz.raw | o_haz.waw | o_haz.str;
  end

endmodule

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard for multi-cycle FP ops (FDIV/FSQRT).
// In: ID fields, issue_fire, mc completion/flush. Out: stall, pending, outstanding, sb_error.
module fp_scoreboard
  import fp_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rs3,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_use_rs3,
  input  logic [4:0]       id_fp_rd,
  input  logic             id_fp_reg_write,
  input  logic             id_is_mc,
  input  logic             issue_fire,
  input  logic             mc_done_valid,
  input  logic [4:0]       mc_done_rd,
  input  logic             mc_flush,
  output logic             stall,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding,
  output logic             sb_error
);

  fp_mask_t         r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  id_fp_t           w_id;
  fp_haz_t          w_haz;
  logic             w_stall;
  logic             w_issue;
  logic             w_inc;
  logic             w_done_ok;
  logic             w_err_set;
  fp_mask_t         w_pend_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_id.valid = id_valid;
  assign w_id.rs1   = id_rs1;
  assign w_id.rs2   = id_rs2;
  assign w_id.rs3   = id_rs3;
  assign w_id.use1  = id_use_rs1;
  assign w_id.use2  = id_use_rs2;
  assign w_id.use3  = id_use_rs3;
  assign w_id.rd    = id_fp_rd;
  assign w_id.rw    = id_fp_reg_write;
  assign w_id.is_mc = id_is_mc;

  fp_sb_hazard_check #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_haz (
    .i_pending     (r_pending),
    .i_outstanding (r_cnt),
    .i_id          (w_id),
    .o_haz         (w_haz),
    .o_stall       (w_stall)
  );

  assign w_issue = issue_fire && id_is_mc &&
                   id_fp_reg_write;

  // A completion only counts if it matches a tracked op.
  assign w_done_ok = mc_done_valid &&
                     r_pending[mc_done_rd] &&
                     (r_cnt != '0);

  // Saturate rather than wrap on an illegal over-issue.
  assign w_inc = w_issue && (r_cnt != '1);

  always_comb begin
    w_pend_nxt = r_pending;
    w_cnt_nxt  = r_cnt;
    if (w_done_ok)
      w_pend_nxt = w_pend_nxt &
                   ~fp_onehot(mc_done_rd);
    // Set after clear: set wins on same rd.
    if (w_issue)
      w_pend_nxt = w_pend_nxt |
                   fp_onehot(id_fp_rd);
    unique case ({w_inc, w_done_ok})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
    if (mc_flush) begin
      w_pend_nxt = '0;
      w_cnt_nxt  = '0;
    end
  end

  // A completion racing a flush is not a violation.
  assign w_err_set =
    (issue_fire && (|w_haz)) ||
    (!mc_flush && mc_done_valid && !w_done_ok) ||
    (w_issue && mc_done_valid &&
     (mc_done_rd == id_fp_rd));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= r_err | w_err_set;
    end
  end

  assign stall       = w_stall;
  assign pending     = r_pending;
  assign outstanding = r_cnt;
  assign sb_error    = r_err;

endmodule

// File: tb/tb_fp_scoreboard.sv
// Directed bench for fp_scoreboard with an expectation queue.
// Two instances: capacity 2 and default capacity 4.
module tb_fp_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rs3;
  logic        id_use_rs1, id_use_rs2, id_use_rs3;
  logic [4:0]  id_fp_rd;
  logic        id_fp_reg_write;
  logic        id_is_mc;
  logic        issue_fire;
  logic        mc_done_valid;
  logic [4:0]  mc_done_rd;
  logic        mc_flush;

  logic        st2, st4;
  logic [31:0] pe2, pe4;
  logic [1:0]  ou2;
  logic [2:0]  ou4;
  logic        er2, er4;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        stall;
    logic [31:0] pend;
    logic [31:0] out;
    logic        err;
    bit          d4;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  fp_scoreboard #(
    .MAX_OUTSTANDING (2),
    .CNT_W           (2)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs3          (id_rs3),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_use_rs3      (id_use_rs3),
    .id_fp_rd        (id_fp_rd),
    .id_fp_reg_write (id_fp_reg_write),
    .id_is_mc        (id_is_mc),
    .issue_fire      (issue_fire),
    .mc_done_valid   (mc_done_valid),
    .mc_done_rd      (mc_done_rd),
    .mc_flush        (mc_flush),
    .stall           (st2),
    .pending         (pe2),
    .outstanding     (ou2),
    .sb_error        (er2)
  );

  fp_scoreboard u_dut4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs3          (id_rs3),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_use_rs3      (id_use_rs3),
    .id_fp_rd        (id_fp_rd),
    .id_fp_reg_write (id_fp_reg_write),
    .id_is_mc        (id_is_mc),
    .issue_fire      (issue_fire),
    .mc_done_valid   (mc_done_valid),
    .mc_done_rd      (mc_done_rd),
    .mc_flush        (mc_flush),
    .stall           (st4),
    .pending         (pe4),
    .outstanding     (ou4),
    .sb_error        (er4)
  );

  function automatic logic [31:0] m(input int i);
    logic [31:0] one;
    one = 32'd1;
    return one << i;
  endfunction

  task automatic idle();
    id_valid        = 1'b0;
    id_rs1          = '0;
    id_rs2          = '0;
    id_rs3          = '0;
    id_use_rs1      = 1'b0;
    id_use_rs2      = 1'b0;
    id_use_rs3      = 1'b0;
    id_fp_rd        = '0;
    id_fp_reg_write = 1'b0;
    id_is_mc        = 1'b0;
    issue_fire      = 1'b0;
    mc_done_valid   = 1'b0;
    mc_done_rd      = '0;
    mc_flush        = 1'b0;
  endtask

  task automatic set_id(
    input logic [4:0] r1, input logic u1,
    input logic [4:0] r2, input logic u2,
    input logic [4:0] r3, input logic u3,
    input logic [4:0] rd, input logic rw,
    input logic mc
  );
    id_valid        = 1'b1;
    id_rs1          = r1;
    id_use_rs1      = u1;
    id_rs2          = r2;
    id_use_rs2      = u2;
    id_rs3          = r3;
    id_use_rs3      = u3;
    id_fp_rd        = rd;
    id_fp_reg_write = rw;
    id_is_mc        = mc;
  endtask

  task automatic done(input logic [4:0] rd);
    mc_done_valid = 1'b1;
    mc_done_rd    = rd;
  endtask

  // Push expectation, compare at the negedge, advance past next posedge.
  task automatic cyc(
    input string       tag,
    input logic        s,
    input logic [31:0] p,
    input int          o,
    input logic        e,
    input bit          d4 = 1'b0
  );
    exp_t x;
    logic        os;
    logic [31:0] op;
    logic [31:0] oo;
    logic        oe;
    x.stall = s;
    x.pend  = p;
    x.out   = 32'(o);
    x.err   = e;
    x.d4    = d4;
    q.push_back(x);
    #4;
    x = q.pop_front();
    os = x.d4 ? st4 : st2;
    op = x.d4 ? pe4 : pe2;
    oo = x.d4 ? 32'(ou4) : 32'(ou2);
    oe = x.d4 ? er4 : er2;
    n_chk++;
    assert (os === x.stall) else begin
      n_fail++;
      $error("FAIL %s stall obs=%b exp=%b",
             tag, os, x.stall);
    end
    n_chk++;
    assert (op === x.pend) else begin
      n_fail++;
      $error("FAIL %s pending obs=%h exp=%h",
             tag, op, x.pend);
    end
    n_chk++;
    assert (oo === x.out) else begin
      n_fail++;
      $error("FAIL %s outstanding obs=%0d exp=%0d",
             tag, oo, x.out);
    end
    n_chk++;
    assert (oe === x.err) else begin
      n_fail++;
      $error("FAIL %s sb_error obs=%b exp=%b",
             tag, oe, x.err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("reset", 0, 0, 0, 0);

    // Basic RAW on f3
    set_id(1, 1, 2, 1, 0, 0, 3, 1, 1);
    issue_fire = 1'b1;
    cyc("raw_issue", 0, 0, 0, 0);
    idle();
    set_id(3, 1, 1, 1, 0, 0, 5, 1, 0);
    cyc("raw_stall", 1, m(3), 1, 0);
    done(3);
    cyc("raw_done_cyc", 1, m(3), 1, 0);
    mc_done_valid = 1'b0;
    issue_fire    = 1'b1;
    cyc("raw_release", 0, 0, 0, 0);

    // f0 tracked like any register
    idle();
    set_id(4, 1, 0, 0, 0, 0, 0, 1, 1);
    issue_fire = 1'b1;
    cyc("f0_issue", 0, 0, 0, 0);
    idle();
    set_id(1, 1, 2, 1, 0, 1, 6, 1, 0);
    cyc("f0_stall", 1, m(0), 1, 0);
    cyc("f0_hold", 1, m(0), 1, 0);
    done(0);
    cyc("f0_done_cyc", 1, m(0), 1, 0);
    mc_done_valid = 1'b0;
    cyc("f0_release", 0, 0, 0, 0);

    // WAW with no source match
    idle();
    set_id(1, 1, 2, 1, 0, 0, 7, 1, 1);
    issue_fire = 1'b1;
    cyc("waw_issue", 0, 0, 0, 0);
    idle();
    set_id(1, 1, 2, 1, 0, 0, 7, 1, 0);
    cyc("waw_stall", 1, m(7), 1, 0);
    idle();
    done(7);
    cyc("waw_done", 0, m(7), 1, 0);
    idle();
    cyc("waw_clear", 0, 0, 0, 0);

    // Capacity 2
    set_id(10, 1, 11, 1, 0, 0, 1, 1, 1);
    issue_fire = 1'b1;
    cyc("cap_i1", 0, 0, 0, 0);
    set_id(10, 1, 11, 1, 0, 0, 2, 1, 1);
    cyc("cap_i2", 0, m(1), 1, 0);
    set_id(10, 1, 11, 1, 0, 0, 4, 1, 1);
    issue_fire = 1'b0;
    done(1);
    cyc("cap_full", 1, m(1) | m(2), 2, 0);
    mc_done_valid = 1'b0;
    issue_fire    = 1'b1;
    cyc("cap_free", 0, m(2), 1, 0);
    idle();
    cyc("cap_refill", 0, m(2) | m(4), 2, 0);
    done(2);
    cyc("drain2", 0, m(2) | m(4), 2, 0);
    done(4);
    cyc("drain4", 0, m(4), 1, 0);

    // Issue f9 while f8 completes
    idle();
    set_id(1, 1, 2, 1, 0, 0, 8, 1, 1);
    issue_fire = 1'b1;
    cyc("sim_pre", 0, 0, 0, 0);
    set_id(1, 1, 2, 1, 0, 0, 9, 1, 1);
    done(8);
    cyc("sim_both", 0, m(8), 1, 0);
    idle();
    cyc("sim_result", 0, m(9), 1, 0);

    // Reset mid-operation
    rst_n = 1'b0;
    cyc("rst2_pre", 0, m(9), 1, 0);
    rst_n = 1'b1;
    cyc("rst2", 0, 0, 0, 0);

    // Flush and errors on the capacity-4 instance
    set_id(10, 1, 11, 1, 0, 0, 1, 1, 1);
    issue_fire = 1'b1;
    cyc("fl_i1", 0, 0, 0, 0, 1);
    set_id(10, 1, 11, 1, 0, 0, 2, 1, 1);
    cyc("fl_i2", 0, m(1), 1, 0, 1);
    set_id(10, 1, 11, 1, 0, 0, 3, 1, 1);
    mc_flush = 1'b1;
    cyc("fl_flush", 0, m(1) | m(2), 2, 0, 1);
    idle();
    cyc("fl_after", 0, 0, 0, 0, 1);
    done(5);
    cyc("spur", 0, 0, 0, 0, 1);
    idle();
    cyc("spur_err", 0, 0, 0, 1, 1);
    cyc("err_sticky", 0, 0, 0, 1, 1);
    rst_n = 1'b0;
    cyc("err_rst_pre", 0, 0, 0, 1, 1);
    rst_n = 1'b1;
    cyc("err_rst", 0, 0, 0, 0, 1);

    // Issue while stalled still updates and flags
    set_id(1, 1, 2, 1, 0, 0, 1, 1, 1);
    issue_fire = 1'b1;
    cyc("viol_pre", 0, 0, 0, 0);
    set_id(3, 1, 4, 1, 0, 0, 1, 1, 0);
    cyc("viol", 1, m(1), 1, 0);
    idle();
    cyc("viol_err", 0, m(1), 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
